// File: rtl/car_pkg.sv
// Shared constants, steering codes and FSM state type for the car speed controller.
// The optional reverse gear is enabled with the SPEED_REVERSE_EN macro.
package car_pkg;

   localparam logic [6:0] Y_NEUTRAL  = 7'd27;
   localparam logic [6:0] Y_MAX      = 7'd54;
   localparam logic [6:0] Y_MIN      = 7'd0;

   localparam logic [1:0] X_STRAIGHT = 2'd0;
   localparam logic [1:0] X_LEFT     = 2'd1;
   localparam logic [1:0] X_RIGHT    = 2'd2;

   typedef enum logic [1:0] {
      S_HOLD = 2'd0,
      S_IDLE = 2'd1,
      S_FWD  = 2'd2,
      S_REV  = 2'd3
   } state_t;

   function automatic logic [6:0] step_toward_neutral(input logic [6:0] y);
      if (y > Y_NEUTRAL)
         return y - 7'd1;
      else if (y < Y_NEUTRAL)
         return y + 7'd1;
      else
         return y;
   endfunction

endpackage

// File: rtl/speed_ctrl_key_sync.sv
// Parameterised-width two-flop synchronizer for raw asynchronous key inputs.
module key_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clock_50,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   logic [WIDTH-1:0] meta_d, meta_q;
   logic [WIDTH-1:0] sync_d, sync_q;

   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
   end

   always_ff @(posedge clock_50) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q;

endmodule

// File: rtl/speed_ctrl.sv
// Car speed/steering controller: tick prescaler, coast counter, drive FSM and speed arithmetic.
// Define SPEED_REVERSE_EN to let braking from standstill drive the car into reverse.
module speed_ctrl
   import car_pkg::*;
#(
   parameter int TICK_DIV  = 2500000,
   parameter int COAST_DIV = 4
) (
   input  logic       clock_50,
   input  logic       reset,
   input  logic       drive_en,
   input  logic       key_accel,
   input  logic       key_brake,
   input  logic       key_left,
   input  logic       key_right,
   output logic [1:0] x_speed,
   output logic [6:0] y_speed,
   output logic       stopped,
   output logic       speed_tick
);

   localparam int CNT_W   = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
   localparam int COAST_W = (COAST_DIV > 1) ? $clog2(COAST_DIV) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TICK_DIV - 1);
   localparam logic [COAST_W-1:0] COAST_LAST = COAST_W'(COAST_DIV - 1);

   logic [3:0] key_s;
   logic       accel_s, brake_s, left_s, right_s;

   key_sync #(.WIDTH(4)) u_key_sync (
      .clock_50 (clock_50),
      .reset    (reset),
      .async_in ({key_accel, key_brake, key_left, key_right}),
      .sync_out (key_s)
   );

   assign {accel_s, brake_s, left_s, right_s} = key_s;

   state_t             state_d, state_q;
   logic [6:0]         y_d, y_q;
   logic [1:0]         x_d, x_q;
   logic [CNT_W-1:0]   cnt_d, cnt_q;
   logic [COAST_W-1:0] coast_d, coast_q;
   logic               tick_d, tick_q;
   logic [6:0]         y_braked;

   // Braking heads toward standstill, or deeper into reverse when the reverse gear exists.
   always_comb begin
`ifdef SPEED_REVERSE_EN
      if (y_q > Y_NEUTRAL)
         y_braked = y_q - 7'd1;
      else if (y_q != Y_MIN)
         y_braked = y_q - 7'd1;
      else
         y_braked = y_q;
`else
      y_braked = (y_q > Y_NEUTRAL) ? y_q - 7'd1 : y_q;
`endif
   end

   always_comb begin
      cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      tick_d  = (cnt_q == CNT_LAST);
      state_d = state_q;
      y_d     = y_q;
      x_d     = x_q;
      coast_d = coast_q;

      if (!drive_en) begin
         state_d = S_HOLD;
         y_d     = Y_NEUTRAL;
         x_d     = X_STRAIGHT;
         coast_d = '0;
      end else if (state_q == S_HOLD) begin
         state_d = S_IDLE;
         x_d     = X_STRAIGHT;
      end else begin
         if (tick_q) begin
            if (brake_s) begin
               coast_d = '0;
               y_d     = y_braked;
            end else if (accel_s) begin
               coast_d = '0;
               y_d     = (y_q < Y_MAX) ? y_q + 7'd1 : Y_MAX;
            end else if (coast_q == COAST_LAST) begin
               coast_d = '0;
               y_d     = step_toward_neutral(y_q);
            end else begin
               coast_d = coast_q + 1'b1;
            end
         end

`ifdef SPEED_REVERSE_EN
         if (y_d > Y_NEUTRAL)
            state_d = S_FWD;
         else if (y_d < Y_NEUTRAL)
            state_d = S_REV;
         else
            state_d = S_IDLE;
`else
         state_d = (y_d > Y_NEUTRAL) ? S_FWD : S_IDLE;
`endif

         // Steering is not tick-gated and only applies while the car is moving.
         if (y_d == Y_NEUTRAL || (left_s && right_s))
            x_d = X_STRAIGHT;
         else if (left_s)
            x_d = X_LEFT;
         else if (right_s)
            x_d = X_RIGHT;
         else
            x_d = X_STRAIGHT;
      end
   end

   always_ff @(posedge clock_50) begin
      if (reset) begin
         state_q <= S_HOLD;
         y_q     <= Y_NEUTRAL;
         x_q     <= X_STRAIGHT;
         cnt_q   <= '0;
         coast_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         coast_q <= coast_d;
         tick_q  <= tick_d;
      end
   end

   assign y_speed    = y_q;
   assign x_speed    = x_q;
   assign speed_tick = tick_q;
   assign stopped    = (y_q == Y_NEUTRAL) && (x_q == X_STRAIGHT);

endmodule

// File: tb/tb_speed_ctrl.sv
// Self-checking bench for speed_ctrl against an integer cycle model of the speed rules.
`timescale 1ns/1ps
module tb_speed_ctrl;
   import car_pkg::*;

   localparam int TICK_DIV  = 4;
   localparam int COAST_DIV = 4;
`ifdef SPEED_REVERSE_EN
   localparam bit REV = 1'b1;
`else
   localparam bit REV = 1'b0;
`endif

   logic       clock_50 = 1'b0;
   logic       reset = 1'b1, drive_en = 1'b0;
   logic       key_accel = 1'b0, key_brake = 1'b0, key_left = 1'b0, key_right = 1'b0;
   logic [1:0] x_speed;
   logic [6:0] y_speed;
   logic       stopped, speed_tick;

   always #10 clock_50 = ~clock_50;

   speed_ctrl #(.TICK_DIV(TICK_DIV), .COAST_DIV(COAST_DIV)) dut (
      .clock_50   (clock_50),
      .reset      (reset),
      .drive_en   (drive_en),
      .key_accel  (key_accel),
      .key_brake  (key_brake),
      .key_left   (key_left),
      .key_right  (key_right),
      .x_speed    (x_speed),
      .y_speed    (y_speed),
      .stopped    (stopped),
      .speed_tick (speed_tick)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: speeds as integers, keys delayed two clocks, ticks by cycle count.
   int         m_y = 27, m_x = 0, m_coast = 0, m_cyc = 0;
   bit         m_hold = 1'b1;
   logic [3:0] m_s1 = '0, m_s2 = '0;
   int         brake_ticks = 0;

   function automatic state_t exp_state();
      if (m_hold)     return S_HOLD;
      if (m_y == 27)  return S_IDLE;
      if (m_y > 27)   return S_FWD;
      return S_REV;
   endfunction

   function automatic logic [12:0] exp_vec();
      return {exp_state(), 7'(m_y), 2'(m_x), 1'(m_y == 27 && m_x == 0),
              1'(m_cyc > 0 && (m_cyc % TICK_DIV) == 0)};
   endfunction

   task automatic cycle();
      bit         tick_pre;
      logic [3:0] vis;
      tick_pre = (m_cyc > 0) && ((m_cyc % TICK_DIV) == 0);
      vis      = m_s2;
      if (reset) begin
         m_y = 27; m_x = 0; m_hold = 1'b1; m_coast = 0; m_cyc = 0; m_s1 = '0; m_s2 = '0;
      end else begin
         m_s2 = m_s1;
         m_s1 = {key_accel, key_brake, key_left, key_right};
         if (!drive_en) begin
            m_hold = 1'b1; m_y = 27; m_x = 0; m_coast = 0;
         end else if (m_hold) begin
            m_hold = 1'b0; m_x = 0;
         end else begin
            if (tick_pre) begin
               if (vis[2]) begin
                  m_coast = 0;
                  brake_ticks++;
                  if (REV) m_y = (m_y > 0) ? m_y - 1 : 0;
                  else     m_y = (m_y > 27) ? m_y - 1 : m_y;
               end else if (vis[3]) begin
                  m_coast = 0;
                  m_y = (m_y < 54) ? m_y + 1 : 54;
               end else begin
                  m_coast++;
                  if (m_coast == COAST_DIV) begin
                     m_coast = 0;
                     m_y = (m_y > 27) ? m_y - 1 : (m_y < 27) ? m_y + 1 : m_y;
                  end
               end
            end
            if (m_y == 27 || (vis[1] && vis[0])) m_x = 0;
            else if (vis[1])                     m_x = 1;
            else if (vis[0])                     m_x = 2;
            else                                 m_x = 0;
         end
         m_cyc++;
      end
      @(posedge clock_50);
      #1;
   endtask

   task automatic set_keys(input logic a, input logic b, input logic l, input logic r);
      key_accel = a; key_brake = b; key_left = l; key_right = r;
   endtask

   // Steers speed to target (>= 27) with accel/brake and releases the keys on arrival.
   task automatic drive_to(input int target);
      int n = 0;
      while (m_y != target && n < 2000) begin
         set_keys(m_y < target, m_y > target, 1'b0, 1'b0);
         cycle();
         n++;
      end
      set_keys(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (m_y != target) begin
         n_fail++;
         $display("FAIL drive_to: reached %0d, required %0d within bound", m_y, target);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; drive_en = 1'b1; set_keys(1'b1, 1'b0, 1'b1, 1'b0);
      cycle(); cycle();
      n_checks++;
      if ({dut.state_q, y_speed, x_speed, stopped, speed_tick} !== {S_HOLD, 7'd27, 2'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: got %h required %h",
                  {dut.state_q, y_speed, x_speed, stopped, speed_tick}, {S_HOLD, 7'd27, 2'd0, 1'b1, 1'b0});
      end
      set_keys(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic test_accel_ramp();
      drive_en = 1'b1; set_keys(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 30 * TICK_DIV + 8; i++) begin
         cycle();
         n_checks++;
         if ({dut.state_q, y_speed, x_speed, stopped, speed_tick} !== exp_vec()) begin
            n_fail++;
            $display("FAIL accel_ramp cyc %0d: got %h required %h", i,
                     {dut.state_q, y_speed, x_speed, stopped, speed_tick}, exp_vec());
         end
      end
      n_checks++;
      if (y_speed !== 7'd54 || stopped !== 1'b0) begin
         n_fail++;
         $display("FAIL accel_saturate: y=%0d stopped=%0b required y=54 stopped=0", y_speed, stopped);
      end
      set_keys(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_coast();
      drive_to(30);
      for (int i = 0; i < 12 * COAST_DIV * TICK_DIV + 4; i++) begin
         cycle();
         n_checks++;
         if ({dut.state_q, y_speed, x_speed, stopped, speed_tick} !== exp_vec()) begin
            n_fail++;
            $display("FAIL coast cyc %0d: got %h required %h", i,
                     {dut.state_q, y_speed, x_speed, stopped, speed_tick}, exp_vec());
         end
      end
      n_checks++;
      if (y_speed !== 7'd27 || stopped !== 1'b1 || dut.state_q !== S_IDLE) begin
         n_fail++;
         $display("FAIL coast_end: y=%0d stopped=%0b required y=27 stopped=1", y_speed, stopped);
      end
   endtask

   task automatic test_both_keys();
      drive_to(40);
      set_keys(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2 + 2 * TICK_DIV && m_y == 40; i++) begin
         cycle();
         n_checks++;
         if ({dut.state_q, y_speed, x_speed, stopped, speed_tick} !== exp_vec()) begin
            n_fail++;
            $display("FAIL brake_wins cyc %0d: got %h required %h", i,
                     {dut.state_q, y_speed, x_speed, stopped, speed_tick}, exp_vec());
         end
      end
      n_checks++;
      if (y_speed !== 7'd39) begin
         n_fail++;
         $display("FAIL brake_wins_value: y=%0d required 39", y_speed);
      end
      set_keys(1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) cycle();
      n_checks++;
      if (x_speed !== 2'd0) begin
         n_fail++;
         $display("FAIL left_right_both: x=%0d required 0", x_speed);
      end
      set_keys(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle();
      n_checks++;
      if (x_speed !== 2'd2) begin
         n_fail++;
         $display("FAIL right_only: x=%0d required 2", x_speed);
      end
      set_keys(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_hold();
      drive_to(45);
      drive_en = 1'b0;
      cycle();
      n_checks++;
      if ({dut.state_q, y_speed, x_speed} !== {S_HOLD, 7'd27, 2'd0}) begin
         n_fail++;
         $display("FAIL drive_en_drop: got %h required %h", {dut.state_q, y_speed, x_speed}, {S_HOLD, 7'd27, 2'd0});
      end
      drive_en = 1'b1;
      cycle();
      n_checks++;
      if (dut.state_q !== S_IDLE) begin
         n_fail++;
         $display("FAIL hold_exit: state=%0d required %0d", dut.state_q, S_IDLE);
      end
      drive_to(45);
      set_keys(1'b1, 1'b0, 1'b1, 1'b0);
      cycle();
      reset = 1'b1;
      cycle();
      n_checks++;
      if ({dut.state_q, y_speed, x_speed, speed_tick} !== {S_HOLD, 7'd27, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_midmotion: got %h required %h",
                  {dut.state_q, y_speed, x_speed, speed_tick}, {S_HOLD, 7'd27, 2'd0, 1'b0});
      end
      reset = 1'b0;
      set_keys(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_brake_idle();
      logic [6:0] want_y;
      state_t     want_s;
      int         n = 0;
      drive_en = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      brake_ticks = 0;
      set_keys(1'b0, 1'b1, 1'b0, 1'b0);
      while (brake_ticks < 5 && n < 200) begin
         cycle();
         n++;
         n_checks++;
         if ({dut.state_q, y_speed, x_speed, stopped, speed_tick} !== exp_vec()) begin
            n_fail++;
            $display("FAIL brake_idle cyc %0d: got %h required %h", n,
                     {dut.state_q, y_speed, x_speed, stopped, speed_tick}, exp_vec());
         end
      end
      set_keys(1'b0, 1'b0, 1'b0, 1'b0);
      want_y = REV ? 7'd22 : 7'd27;
      want_s = REV ? S_REV : S_IDLE;
      n_checks++;
      if (y_speed !== want_y || dut.state_q !== want_s) begin
         n_fail++;
         $display("FAIL brake_at_neutral: y=%0d state=%0d required y=%0d state=%0d",
                  y_speed, dut.state_q, want_y, want_s);
      end
      drive_en = 1'b0;
      cycle();
      drive_en = 1'b1;
      cycle();
   endtask

   task automatic test_pulse_and_steer();
      logic [6:0] y_before;
      int n = 0;
      drive_to(33);
      while ((m_cyc % TICK_DIV) != 1 && n < 20) begin cycle(); n++; end
      y_before = y_speed;
      set_keys(1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      set_keys(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2 * TICK_DIV; i++) cycle();
      n_checks++;
      if (y_speed !== y_before) begin
         n_fail++;
         $display("FAIL short_pulse: y=%0d required %0d", y_speed, y_before);
      end
      drive_to(27);
      set_keys(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle();
      n_checks++;
      if (x_speed !== 2'd0) begin
         n_fail++;
         $display("FAIL left_at_neutral: x=%0d required 0", x_speed);
      end
      drive_to(28);
      set_keys(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(); cycle();
      n_checks++;
      if (x_speed !== 2'd0) begin
         n_fail++;
         $display("FAIL left_latency_early: x=%0d required 0", x_speed);
      end
      cycle();
      n_checks++;
      if (x_speed !== 2'd1 || stopped !== 1'b0) begin
         n_fail++;
         $display("FAIL left_moving: x=%0d stopped=%0b required x=1 stopped=0", x_speed, stopped);
      end
      set_keys(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         drive_en = ($urandom_range(0, 63) != 0);
         reset    = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 11) == 0) key_accel = $urandom_range(0, 1);
         if ($urandom_range(0, 11) == 0) key_brake = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 5) == 0)  key_left  = $urandom_range(0, 1);
         if ($urandom_range(0, 5) == 0)  key_right = $urandom_range(0, 1);
         cycle();
         n_checks++;
         if ({dut.state_q, y_speed, x_speed, stopped, speed_tick} !== exp_vec()) begin
            n_fail++;
            $display("FAIL random cyc %0d: got %h required %h", i,
                     {dut.state_q, y_speed, x_speed, stopped, speed_tick}, exp_vec());
         end
      end
      reset = 1'b0;
      set_keys(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_accel_ramp();
      test_coast();
      test_both_keys();
      test_hold();
      test_brake_idle();
      test_pulse_and_steer();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
